// File: rtl/alarm_clock_pkg.sv
// Shared constants for the alarm clock timebase and time-of-day logic.
package alarm_clock_pkg;
    localparam int CLKS_PER_SEC_DEF = 256;
    localparam int SECS_PER_MIN     = 60;
    localparam int SEC_W            = 6;
endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous clear and enable; wrap flags the terminal count.
module mod_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);
    logic [W-1:0] count_reg;

    assign count = count_reg;
    assign wrap  = en && (count_reg == W'(N - 1));

    // clr outranks en, so a wrap coinciding with clr is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= wrap ? '0 : count_reg + W'(1);
        end
    end
endmodule

// File: rtl/time_gen.sv
// Timebase generator: one-cycle second and minute strobes plus the running seconds count.
module time_gen
    import alarm_clock_pkg::*;
#(
    parameter int CLKS_PER_SEC = CLKS_PER_SEC_DEF,
    parameter int SECS_PER_MIN = alarm_clock_pkg::SECS_PER_MIN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_count,
    input  logic             fast_watch,
    output logic             one_second,
    output logic             one_minute,
    output logic [SEC_W-1:0] seconds
);
    localparam int PRE_W = $clog2(CLKS_PER_SEC);

    logic [PRE_W-1:0] pre_count;
    logic             sec_tick;
    logic             min_tick;
    logic             one_second_reg;
    logic             one_minute_reg;

    mod_counter #(.N(CLKS_PER_SEC), .W(PRE_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (reset_count),
        .en    (1'b1),
        .count (pre_count),
        .wrap  (sec_tick)
    );

    mod_counter #(.N(SECS_PER_MIN), .W(SEC_W)) u_seconds (
        .clk   (clk),
        .reset (reset),
        .clr   (reset_count),
        .en    (sec_tick),
        .count (seconds),
        .wrap  (min_tick)
    );

    // fast_watch only picks the minute source; both counters run regardless
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            one_second_reg <= 1'b0;
            one_minute_reg <= 1'b0;
        end else if (reset_count) begin
            one_second_reg <= 1'b0;
            one_minute_reg <= 1'b0;
        end else begin
            one_second_reg <= sec_tick;
            one_minute_reg <= fast_watch ? sec_tick : min_tick;
        end
    end

    assign one_second = one_second_reg;
    assign one_minute = one_minute_reg;

    a_sec_single: assert property (@(posedge clk) disable iff (!reset)
        one_second |=> !one_second);
    a_min_in_sec: assert property (@(posedge clk) disable iff (!reset)
        one_minute |-> one_second);
    a_sec_range: assert property (@(posedge clk) disable iff (!reset)
        32'(seconds) < SECS_PER_MIN);
    a_pre_range: assert property (@(posedge clk) disable iff (!reset)
        32'(pre_count) < CLKS_PER_SEC);
    a_realign: assert property (@(posedge clk) disable iff (!reset)
        reset_count |=> (!one_second && seconds == '0));
endmodule

// File: tb/tb_time_gen.sv
// Randomized and directed bench for time_gen against an elapsed-time reference model.
module tb_time_gen;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reset_count = 1'b0;
    logic       fast_watch = 1'b0;
    logic       one_second;
    logic       one_minute;
    logic [5:0] seconds;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit os;
        bit om;
        int sec;
    } exp_t;

    exp_t q[$];
    int   t = 0;  // edges since the timebase was last aligned

    time_gen #(.CLKS_PER_SEC(C)) dut (
        .clk         (clk),
        .reset       (reset),
        .reset_count (reset_count),
        .fast_watch  (fast_watch),
        .one_second  (one_second),
        .one_minute  (one_minute),
        .seconds     (seconds)
    );

    always #5 clk = ~clk;

    // Reference model: outputs follow purely from elapsed edges since alignment.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!reset) begin
                t = 0;
            end else begin
                if (reset_count) t = 0;
                else t = t + 1;
                e.os  = !reset_count && (t > 0) && (t % C == 0);
                e.sec = (t / C) % 60;
                e.om  = e.os && (fast_watch || e.sec == 0);
                q.push_back(e);
            end
        end
    end

    // Monitor: compares every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (!reset) begin
                if (one_second || one_minute || seconds != 0) begin
                    fails++;
                    $display("FAIL reset_outputs: got os=%0b om=%0b sec=%0d, need 0 0 0",
                             one_second, one_minute, seconds);
                end
            end else if (q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty: got output with no expectation, need one queued");
            end else begin
                e = q.pop_front();
                if (one_second !== e.os || one_minute !== e.om || 32'(seconds) != e.sec) begin
                    fails++;
                    $display("FAIL cycle_t%0d: got os=%0b om=%0b sec=%0d, need os=%0b om=%0b sec=%0d",
                             t, one_second, one_minute, seconds, e.os, e.om, e.sec);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic first_minute_check(input string name);
        int n;
        bit found;
        n = 0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick(1);
            n++;
            if (one_minute) found = 1;
        end
        checks++;
        if (!found || n != 240 || seconds != 0) begin
            fails++;
            $display("FAIL %s: got first minute at edge %0d (found=%0b sec=%0d), need edge 240 sec=0",
                     name, n, found, seconds);
        end
    endtask

    task automatic wait_second_pulse(input int sec, input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick(1);
            if (one_second && seconds == 6'(sec)) ok = 1;
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL %s: got no pulse with seconds=%0d within bound, need one", name, sec);
        end
    endtask

    initial begin
        bit ok;
        int ns, nm, maxsec;

        // Scenario 1: release from reset, normal mode
        tick(3);
        reset = 1'b1;
        first_minute_check("first_minute_after_reset");
        tick(30);

        // Scenario 2: fast_watch from reset
        reset = 1'b0;
        tick(2);
        fast_watch = 1'b1;
        reset = 1'b1;
        tick(50);

        // Scenario 3: switch to fast_watch at seconds=30, prescaler=2
        fast_watch = 1'b0;
        reset_count = 1'b1;
        tick(1);
        reset_count = 1'b0;
        wait_second_pulse(30, "wait_sec30", ok);
        tick(2);
        fast_watch = 1'b1;
        tick(2);
        checks++;
        if (!one_minute || seconds != 31) begin
            fails++;
            $display("FAIL fast_switch: got om=%0b sec=%0d, need om=1 sec=31", one_minute, seconds);
        end
        tick(40);

        // Scenario 4: reset_count exactly when prescaler is at C-1
        fast_watch = 1'b0;
        for (int i = 0; i < 10 && (t % C) != C - 1; i++) tick(1);
        reset_count = 1'b1;
        tick(1);
        reset_count = 1'b0;
        checks++;
        if (one_second || seconds != 0) begin
            fails++;
            $display("FAIL rc_discards_tick: got os=%0b sec=%0d, need os=0 sec=0", one_second, seconds);
        end
        tick(20);

        // Scenario 5: asynchronous reset mid-minute
        wait_second_pulse(45, "wait_sec45", ok);
        reset = 1'b0;
        #1;
        checks++;
        if (one_second || one_minute || seconds != 0) begin
            fails++;
            $display("FAIL async_reset: got os=%0b om=%0b sec=%0d, need 0 0 0",
                     one_second, one_minute, seconds);
        end
        tick(3);
        reset = 1'b1;
        first_minute_check("first_minute_after_async_reset");

        // Scenario 6: two full minutes counted
        reset_count = 1'b1;
        tick(1);
        reset_count = 1'b0;
        ns = 0;
        nm = 0;
        maxsec = 0;
        for (int i = 0; i < 120 * C; i++) begin
            tick(1);
            if (one_second) ns++;
            if (one_minute) nm++;
            if (int'(seconds) > maxsec) maxsec = int'(seconds);
        end
        checks++;
        if (ns != 120 || nm != 2 || maxsec != 59 || seconds != 0) begin
            fails++;
            $display("FAIL two_minutes: got os=%0d om=%0d maxsec=%0d sec=%0d, need 120 2 59 0",
                     ns, nm, maxsec, seconds);
        end

        // Random phase: fast_watch toggles and sporadic realigns
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) fast_watch = ~fast_watch;
            reset_count = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        reset_count = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no completion, need completion before time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "timeout");
    end
endmodule
